// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch front end. Owns the fetch PC and issues word reads to
//   instruction memory over a req/ack handshake with at most one request
//   outstanding. Returned {pc, instruction} pairs are buffered in a small
//   FIFO for decode. A redirect loads a new fetch PC and flushes the buffer.
//
// Ports
//   clk             in   1   clock, rising edge
//   clr             in   1   asynchronous, active-high reset
//   redirect_valid  in   1   load new fetch PC this cycle
//   redirect_addr   in   32  redirect target, bits [1:0] forced to zero
//   imem_req        out  1   memory read request, held until ack
//   imem_addr       out  32  request address, stable while imem_req=1
//   imem_ack        in   1   one-cycle pulse, imem_rdata valid
//   imem_rdata      in   32  instruction word
//   inst_valid      out  1   FIFO head valid
//   inst_data       out  32  FIFO head instruction
//   inst_pc         out  32  FIFO head PC
//   inst_ready      in   1   decode accepts head this cycle
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_addr;
    logic [31:0]   r_pending;
    logic          r_req;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    state_t        w_state_n;
    logic [31:0]   w_fetch_pc_n;
    logic [31:0]   w_addr_n;
    logic [31:0]   w_pending_n;
    logic [31:0]   w_redir;
    logic [31:0]   w_target;
    logic [31:0]   w_addr_inc;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic [CW-1:0] w_count_n;
    logic          w_room;

    assign w_redir    = redirect_addr & ~32'h3;
    assign w_addr_inc = r_addr + 32'd4;
    assign w_pop      = (r_count != '0) && inst_ready;
    assign w_flush    = redirect_valid;
    // Returned data is only kept for a live BUSY request without a redirect;
    // DRAIN acks belong to an abandoned address and are dropped.
    assign w_push     = (r_state == S_BUSY) && imem_ack && !redirect_valid;

    // Room is judged on the occupancy after this cycle's flush/push/pop, so a
    // new request is only issued when its data is guaranteed a slot.
    assign w_count_n  = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_room     = (w_count_n < CW'(DEPTH));

    // Newest redirect wins even when it lands in the same cycle as the ack.
    assign w_target   = redirect_valid ? w_redir : r_pending;

    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_addr_n     = r_addr;
        w_pending_n  = r_pending;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_n = w_redir;
                end else if (w_room) begin
                    w_state_n = S_BUSY;
                    w_addr_n  = r_fetch_pc;
                end
            end
            S_BUSY: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_fetch_pc_n = w_redir;
                        w_addr_n     = w_redir;
                    end else begin
                        w_fetch_pc_n = w_addr_inc;
                        if (w_room) begin
                            w_addr_n = w_addr_inc;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    w_pending_n = w_redir;
                    w_state_n   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    w_pending_n = w_redir;
                end
                if (imem_ack) begin
                    w_fetch_pc_n = w_target;
                    w_addr_n     = w_target;
                    w_state_n    = S_BUSY;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_pending  <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_addr     <= w_addr_n;
            r_pending  <= w_pending_n;
            r_req      <= (w_state_n != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else if (w_flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_count <= w_count_n;
            if (w_push) begin
                r_fifo_pc[r_wptr]   <= r_addr;
                r_fifo_data[r_wptr] <= imem_rdata;
                r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = (r_count != '0);
    assign inst_data  = r_fifo_data[r_rptr];
    assign inst_pc    = r_fifo_pc[r_rptr];

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
//   Self-checking bench for ifetch_unit. A behavioural instruction memory
//   answers requests after a programmable latency with a hashed word of the
//   address. Expected PCs are queued as stimulus is driven; popped FIFO heads
//   are queued as observed and compared per scenario.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int unsigned cyc;
    } obs_t;

    obs_t        obs_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned mem_lat  = 0;
    int unsigned mem_wait = 0;

    ifetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .clr            (clr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // One clock: record a pop, advance past the edge, then let memory respond.
    task automatic step();
        obs_t o;
        if (inst_valid && inst_ready) begin
            o.pc   = inst_pc;
            o.data = inst_data;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (clr || !imem_req) begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end else if (mem_wait >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_wait   = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_DEAD;
            mem_wait++;
        end
    endtask

    task automatic do_clr(input int unsigned lat);
        clr            = 1'b1;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        mem_wait       = 0;
        mem_lat        = lat;
        step();
        step();
        obs_q.delete();
        exp_q.delete();
        clr = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        timed_out = (obs_q.size() < n);
    endtask

    task automatic test_reset();
        clr            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        inst_ready     = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        #1;
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 00000000", imem_addr);
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid);
        end
        clr = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        bit          to;
        obs_t        o;
        logic [31:0] e;
        int unsigned prev;
        do_clr(1);
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        collect(6, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL stream_timeout: got %0d entries want 6", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL stream[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
            if (i > 0) begin
                n_checks++;
                if (o.cyc - prev !== 2) begin
                    n_fail++; $display("FAIL stream_gap[%0d]: got %0d cycles want 2", i, o.cyc - prev);
                end
            end
            prev = o.cyc;
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_fill();
        bit          to;
        obs_t        o;
        logic [31:0] e;
        do_clr(0);
        inst_ready = 1'b0;
        repeat (10) step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL fill_stop: got req=%b want 0", imem_req);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL fill_head: got valid=%b pc=%h want valid=1 pc=00000000", inst_valid, inst_pc);
        end
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL fill_refill: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL fill_single: got req=%b want 0", imem_req);
        end
        inst_ready = 1'b1;
        collect(7, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL fill_timeout: got %0d entries want 7", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL fill[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_pending();
        bit          to;
        int          k;
        obs_t        o;
        logic [31:0] e;
        do_clr(3);
        inst_ready = 1'b0;
        k = 0;
        while (!(imem_req && imem_addr == 32'h8) && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (!(imem_req && imem_addr == 32'h8)) begin
            n_fail++; $display("FAIL redir_wait8: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL redir_drain: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00000008", inst_valid, imem_req, imem_addr);
        end
        k = 0;
        while (imem_addr == 32'h8 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL redir_newreq: got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        end
        inst_ready = 1'b1;
        collect(3, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL redir_timeout: got %0d entries want 3", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL redir[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_double_redirect();
        bit          to;
        int          k;
        obs_t        o;
        logic [31:0] e;
        do_clr(4);
        inst_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        step();
        redirect_addr  = 32'h302;
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL dbl_hold: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
        k = 0;
        while (imem_addr == 32'h0 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL dbl_target: got req=%b addr=%h want req=1 addr=00000300", imem_req, imem_addr);
        end
        inst_ready = 1'b1;
        collect(2, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL dbl_timeout: got %0d entries want 2", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL dbl[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_ack_pop();
        bit          to;
        int          k;
        obs_t        o;
        logic [31:0] e;
        do_clr(0);
        inst_ready = 1'b1;
        k = 0;
        while (!(inst_valid && imem_ack) && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (!(inst_valid && imem_ack)) begin
            n_fail++; $display("FAIL rap_setup: got valid=%b ack=%b want 1 1", inst_valid, imem_ack);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'h400;
        step();
        redirect_valid = 1'b0;
        obs_q.delete();
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rap_flush: got valid=%b want 0", inst_valid);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            n_fail++; $display("FAIL rap_addr: got req=%b addr=%h want req=1 addr=00000400", imem_req, imem_addr);
        end
        collect(3, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL rap_timeout: got %0d entries want 3", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL rap[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_wrap_and_clr();
        bit          to;
        obs_t        o;
        logic [31:0] e;
        do_clr(0);
        inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        obs_q.delete();
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        collect(3, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL wrap_timeout: got %0d entries want 3", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL wrap[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        step();
        clr = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL clr_async: got req=%b valid=%b addr=%h want 0 0 00000000", imem_req, inst_valid, imem_addr);
        end
        step();
        step();
        obs_q.delete();
        exp_q.delete();
        clr = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL clr_restart: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        end
        collect(2, 40, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL restart_timeout: got %0d entries want 2", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e || o.data !== mem_word(e)) begin
                n_fail++; $display("FAIL restart[%0d]: got pc=%h data=%h want pc=%h data=%h", i, o.pc, o.data, e, mem_word(e));
            end
        end
        inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_pending();
        test_double_redirect();
        test_redirect_ack_pop();
        test_wrap_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
